pc_sequencer: RTL and testbench

Control FSM that sequences the program counter for the core. It starts execution on a `start` pulse and issues fetch addresses with a valid strobe. It resolves decoded branch/jump requests against a programmable 32-entry target lookup table, and signals normal completion (`done`) or an error trap. It sits between the instruction decoder and instruction memory, replacing hard-coded PC offsets with table-driven targets.

---
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 tb/tb_pc_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of the decoder-facing request signals, target-table configuration
// port and fetch outputs of the PC sequencer.
interface pc_sequencer_if #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   // Requests from the decoder / control side
   logic              start;
   logic              stall;
   logic              halt_instr;
   logic              jmp_req;
   logic              br_req;
   logic              br_cond;
   logic [LUT_AW-1:0] lut_idx;

   // Target-table write port
   logic              cfg_we;
   logic [LUT_AW-1:0] cfg_addr;
   logic [PC_W-1:0]   cfg_data;

   // Fetch side and status
   logic [PC_W-1:0]   pc_out;
   logic              pc_valid;
   logic              done;
   logic              trap;
   logic [CNT_W-1:0]  cycle_cnt;

   // Driver of requests and configuration, consumer of fetch addresses
   modport master (
      output start, stall, halt_instr, jmp_req, br_req, br_cond, lut_idx,
      output cfg_we, cfg_addr, cfg_data,
      input  pc_out, pc_valid, done, trap, cycle_cnt
   );

   // The sequencer itself
   modport slave (
      input  start, stall, halt_instr, jmp_req, br_req, br_cond, lut_idx,
      input  cfg_we, cfg_addr, cfg_data,
      output pc_out, pc_valid, done, trap, cycle_cnt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues fetch addresses after a start pulse,
// resolves jumps/branches through a programmable target table, and stops
// either normally (done) or on an illegal address (trap).
module pc_sequencer #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned LUT_AW = 5,
   parameter int unsigned MAX_PC = 1023,
   parameter int unsigned CNT_W  = 16
) (
   input logic            i_clk,
   input logic            i_init,
   pc_sequencer_if.slave  io_bus
);

   localparam int unsigned   LutDepth = 2 ** LUT_AW;
   localparam logic [PC_W-1:0] MaxPc  = PC_W'(MAX_PC);

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StRedirect,
      StHalt,
      StTrap
   } state_e;

   state_e           r_state;
   logic [PC_W-1:0]  r_pc;
   logic             r_valid;
   logic             r_done;
   logic             r_trap;
   logic [CNT_W-1:0] r_cnt;
   logic [PC_W-1:0]  r_lut [LutDepth];

   logic [PC_W-1:0]  w_target;
   logic             w_take;
   logic             w_target_bad;
   logic             w_at_end;

   // Table read sees the registered contents, so a same-cycle write is not yet visible
   assign w_target     = r_lut[io_bus.lut_idx];
   assign w_take       = io_bus.jmp_req | (io_bus.br_req & io_bus.br_cond);
   assign w_target_bad = (w_target > MaxPc);
   assign w_at_end     = (r_pc == MaxPc);

   // Target table: cleared by init, otherwise written from the config port in any state
   always_ff @(posedge i_clk) begin
      if (i_init) begin
         for (int i = 0; i < LutDepth; i++) begin
            r_lut[i] <= '0;
         end
      end else if (io_bus.cfg_we) begin
         r_lut[io_bus.cfg_addr] <= io_bus.cfg_data;
      end
   end

   // Sequencing FSM with all outputs registered alongside the state
   always_ff @(posedge i_clk) begin
      if (i_init) begin
         r_state <= StIdle;
         r_pc    <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_trap  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle, StHalt: begin
               if (io_bus.start) begin
                  r_state <= StRun;
                  r_pc    <= '0;
                  r_valid <= 1'b1;
                  r_done  <= 1'b0;
                  r_cnt   <= '0;
               end
            end

            StRun: begin
               // Counts every RUN cycle, stalled ones included
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (io_bus.stall) begin
                  // Hold everything; requests are re-evaluated once the stall drops
               end else if (io_bus.halt_instr) begin
                  r_state <= StHalt;
                  r_done  <= 1'b1;
                  r_valid <= 1'b0;
               end else if (w_take) begin
                  r_valid <= 1'b0;
                  if (w_target_bad) begin
                     r_state <= StTrap;
                     r_trap  <= 1'b1;
                  end else begin
                     r_state <= StRedirect;
                     r_pc    <= w_target;
                  end
               end else if (w_at_end) begin
                  // No wrap past the last legal address
                  r_state <= StTrap;
                  r_trap  <= 1'b1;
                  r_valid <= 1'b0;
               end else begin
                  r_pc <= r_pc + 1'b1;
               end
            end

            StRedirect: begin
               // One bubble while the new target is fetched; inputs are ignored
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               r_state <= StRun;
               r_valid <= 1'b1;
            end

            StTrap: begin
               // Sticky until init
               r_valid <= 1'b0;
               r_trap  <= 1'b1;
            end

            default: begin
               r_state <= StIdle;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign io_bus.pc_out    = r_pc;
   assign io_bus.pc_valid  = r_valid;
   assign io_bus.done      = r_done;
   assign io_bus.trap      = r_trap;
   assign io_bus.cycle_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a scoreboard of expected fetch
// addresses is filled as stimulus is applied and drained by a monitor on
// every valid fetch; status outputs are checked directly.
module tb_pc_sequencer;

   localparam int unsigned PC_W   = 10;
   localparam int unsigned LUT_AW = 5;
   localparam int unsigned CNT_W  = 16;

   logic clk;
   logic a_init;
   logic b_init;

   int n_tests = 0;
   int n_fail  = 0;
   int sb_q[$];

   pc_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) a_if ();
   pc_sequencer_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) b_if ();

   pc_sequencer #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW),
      .MAX_PC (1023),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk  (clk),
      .i_init (a_init),
      .io_bus (a_if)
   );

   // Small-address-space instance for the table-target trap cases
   pc_sequencer #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW),
      .MAX_PC (50),
      .CNT_W  (CNT_W)
   ) dut_s (
      .i_clk  (clk),
      .i_init (b_init),
      .io_bus (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Expected fetch after the coming edge is queued before the edge
   task automatic tick(input bit exp_v, input int exp_pc);
      if (exp_v) sb_q.push_back(exp_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic check_a_zero(input string tag);
      check_val({tag, "_pc"},    32'(a_if.pc_out),    0);
      check_val({tag, "_valid"}, 32'(a_if.pc_valid),  0);
      check_val({tag, "_done"},  32'(a_if.done),      0);
      check_val({tag, "_trap"},  32'(a_if.trap),      0);
      check_val({tag, "_cnt"},   32'(a_if.cycle_cnt), 0);
   endtask

   task automatic clear_req_a();
      a_if.start = 0; a_if.stall = 0; a_if.halt_instr = 0; a_if.jmp_req = 0;
      a_if.br_req = 0; a_if.br_cond = 0; a_if.lut_idx = '0;
      a_if.cfg_we = 0; a_if.cfg_addr = '0; a_if.cfg_data = '0;
   endtask

   task automatic clear_req_b();
      b_if.start = 0; b_if.stall = 0; b_if.halt_instr = 0; b_if.jmp_req = 0;
      b_if.br_req = 0; b_if.br_cond = 0; b_if.lut_idx = '0;
      b_if.cfg_we = 0; b_if.cfg_addr = '0; b_if.cfg_data = '0;
   endtask

   // Monitor: each valid fetch must match the oldest expected address
   always @(negedge clk) begin
      if (a_if.pc_valid === 1'b1) begin
         check_val("sb_nonempty", 32'(sb_q.size() > 0), 1);
         if (sb_q.size() > 0) begin
            check_val("fetch_pc", 32'(a_if.pc_out), 32'(sb_q.pop_front()));
         end
      end
   end

   initial begin
      clear_req_a();
      clear_req_b();
      a_init = 1;
      b_init = 1;
      tick(0, 0);
      tick(0, 0);
      a_init = 0;
      b_init = 0;
      check_a_zero("reset");

      // Program targets while idle
      a_if.cfg_we = 1; a_if.cfg_addr = 3; a_if.cfg_data = 40;
      tick(0, 0);
      a_if.cfg_addr = 1; a_if.cfg_data = 100;
      tick(0, 0);
      a_if.cfg_we = 0;

      // Start and sequential fetch
      a_if.start = 1;
      tick(1, 0);
      a_if.start = 0;
      check_val("start_cnt", 32'(a_if.cycle_cnt), 0);
      tick(1, 1);
      tick(1, 2);
      check_val("seq_cnt", 32'(a_if.cycle_cnt), 2);

      // Jump through lut[3]
      a_if.jmp_req = 1; a_if.lut_idx = 3;
      tick(0, 0);
      a_if.jmp_req = 0;
      check_val("jmp_pc", 32'(a_if.pc_out), 40);
      check_val("jmp_bubble", 32'(a_if.pc_valid), 0);
      tick(1, 40);
      tick(1, 41);

      // Branch not taken, then taken through lut[1]
      a_if.br_req = 1; a_if.br_cond = 0;
      tick(1, 42);
      a_if.br_cond = 1; a_if.lut_idx = 1;
      tick(0, 0);
      a_if.br_req = 0; a_if.br_cond = 0;
      check_val("br_pc", 32'(a_if.pc_out), 100);
      tick(1, 100);
      check_val("br_cnt", 32'(a_if.cycle_cnt), 8);

      // Stall with a pending jump: held, then taken on release
      a_if.stall = 1; a_if.jmp_req = 1; a_if.lut_idx = 3;
      tick(1, 100);
      tick(1, 100);
      tick(1, 100);
      a_if.stall = 0;
      tick(0, 0);
      a_if.jmp_req = 0;
      check_val("stall_jmp_pc", 32'(a_if.pc_out), 40);
      tick(1, 40);
      check_val("stall_cnt", 32'(a_if.cycle_cnt), 13);

      // Same-cycle write to the index being read uses the old entry
      a_if.cfg_we = 1; a_if.cfg_addr = 3; a_if.cfg_data = 200;
      a_if.jmp_req = 1; a_if.lut_idx = 3;
      tick(0, 0);
      a_if.cfg_we = 0; a_if.jmp_req = 0;
      check_val("wr_rd_old", 32'(a_if.pc_out), 40);
      tick(1, 40);
      a_if.jmp_req = 1;
      tick(0, 0);
      a_if.jmp_req = 0;
      check_val("wr_rd_new", 32'(a_if.pc_out), 200);
      tick(1, 200);

      // Halt, then restart from HALT
      a_if.halt_instr = 1;
      tick(0, 0);
      a_if.halt_instr = 0;
      check_val("halt_done", 32'(a_if.done), 1);
      check_val("halt_pc", 32'(a_if.pc_out), 200);
      tick(0, 0);
      check_val("halt_hold_done", 32'(a_if.done), 1);
      check_val("halt_hold_cnt", 32'(a_if.cycle_cnt), 18);
      a_if.start = 1;
      tick(1, 0);
      a_if.start = 0;
      check_val("restart_done", 32'(a_if.done), 0);
      check_val("restart_cnt", 32'(a_if.cycle_cnt), 0);

      // Init in the middle of a redirect; a concurrent table write must lose
      tick(1, 1);
      a_if.jmp_req = 1; a_if.lut_idx = 1;
      tick(0, 0);
      a_if.jmp_req = 0;
      a_init = 1;
      a_if.cfg_we = 1; a_if.cfg_addr = 1; a_if.cfg_data = 55;
      tick(0, 0);
      a_init = 0;
      a_if.cfg_we = 0;
      check_a_zero("init_redir");

      // Table was cleared: lut[1] now targets 0
      a_if.start = 1;
      tick(1, 0);
      a_if.start = 0;
      tick(1, 1);
      a_if.jmp_req = 1; a_if.lut_idx = 1;
      tick(0, 0);
      a_if.jmp_req = 0;
      check_val("lut_cleared", 32'(a_if.pc_out), 0);
      tick(1, 0);

      // Run off the end of the address space
      for (int i = 1; i <= 1023; i++) begin
         tick(1, i);
      end
      tick(0, 0);
      check_val("end_trap", 32'(a_if.trap), 1);
      check_val("end_valid", 32'(a_if.pc_valid), 0);
      check_val("end_pc", 32'(a_if.pc_out), 1023);
      a_if.start = 1;
      tick(0, 0);
      a_if.start = 0;
      check_val("trap_start_trap", 32'(a_if.trap), 1);
      check_val("trap_start_valid", 32'(a_if.pc_valid), 0);
      check_val("trap_cnt", 32'(a_if.cycle_cnt), 1027);
      a_init = 1;
      tick(0, 0);
      a_init = 0;
      check_a_zero("init_trap");

      // MAX_PC = 50 instance: target exactly at the limit is legal
      b_if.cfg_we = 1; b_if.cfg_addr = 0; b_if.cfg_data = 60;
      tick(0, 0);
      b_if.cfg_addr = 1; b_if.cfg_data = 50;
      tick(0, 0);
      b_if.cfg_we = 0;
      b_if.start = 1;
      tick(0, 0);
      b_if.start = 0;
      b_if.jmp_req = 1; b_if.lut_idx = 1;
      tick(0, 0);
      b_if.jmp_req = 0;
      check_val("s_jmp50_pc", 32'(b_if.pc_out), 50);
      check_val("s_jmp50_trap", 32'(b_if.trap), 0);
      tick(0, 0);
      check_val("s_at50_valid", 32'(b_if.pc_valid), 1);
      tick(0, 0);
      check_val("s_end_trap", 32'(b_if.trap), 1);

      // Jump target above the limit
      b_init = 1;
      tick(0, 0);
      b_init = 0;
      check_val("s_init_trap", 32'(b_if.trap), 0);
      b_if.cfg_we = 1; b_if.cfg_addr = 0; b_if.cfg_data = 60;
      tick(0, 0);
      b_if.cfg_we = 0;
      b_if.start = 1;
      tick(0, 0);
      b_if.start = 0;
      b_if.jmp_req = 1; b_if.lut_idx = 0;
      tick(0, 0);
      b_if.jmp_req = 0;
      check_val("s_bad_tgt_trap", 32'(b_if.trap), 1);
      check_val("s_bad_tgt_valid", 32'(b_if.pc_valid), 0);
      b_init = 1;
      tick(0, 0);
      b_init = 0;
      check_val("s_reinit_trap", 32'(b_if.trap), 0);
      check_val("s_reinit_pc", 32'(b_if.pc_out), 0);

      tick(0, 0);
      check_val("sb_drain", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
